// File: rtl/fetch_stage.sv
// RV64 fetch stage: one outstanding bus request, registered output FIFO.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned fetch PCs into fault entries.
module fetch_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_raw_instr,
  output logic        out_misalign,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [63:0] redir_pc;

  logic [DEPTH-1:0][63:0] pc_q;
  logic [DEPTH-1:0][31:0] ins_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d, cnt_pop;

  logic        push, pop;
  logic [63:0] push_pc;
  logic [31:0] push_ins;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic             push_mis;
  logic [DEPTH-1:0] mis_q;
  assign redir_pc     = redirect_pc;
  assign out_misalign = mis_q[rd_q];
`else
  assign redir_pc     = redirect_pc & ~64'h3;
  assign out_misalign = 1'b0;
`endif

  assign ireq_valid    = (state_q == S_BUSY) || (state_q == S_DRAIN);
  assign ireq_addr     = {req_pc_q[63:2], 2'b00};
  assign out_valid     = (cnt_q != '0);
  assign out_pc        = pc_q[rd_q];
  assign out_raw_instr = ins_q[rd_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    push_pc    = req_pc_q;
    push_ins   = iresp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    push_mis   = 1'b0;
`endif
    pop        = out_valid & out_ready & ~redirect_valid;
    cnt_pop    = cnt_q - (pop ? ONE_W : '0);
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      state_d    = S_IDLE;
      if (ireq_valid && !iresp_data_ok)
        state_d = S_DRAIN;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cnt_pop < DEPTH_W) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (fetch_pc_q[1:0] != 2'b00) begin
              push     = 1'b1;
              push_pc  = fetch_pc_q;
              push_ins = '0;
              push_mis = 1'b1;
              state_d  = S_FAULT;
            end else begin
              state_d  = S_BUSY;
              req_pc_d = fetch_pc_q;
            end
`else
            state_d  = S_BUSY;
            req_pc_d = fetch_pc_q;
`endif
          end
        end
        S_BUSY: begin
          if (iresp_data_ok) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 64'd4;
            // keep the bus busy back-to-back while the FIFO can absorb it
            if ((cnt_pop + ONE_W) < DEPTH_W)
              req_pc_d = fetch_pc_q + 64'd4;
            else
              state_d = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (iresp_data_ok)
            state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign cnt_d = redirect_valid ? '0 :
                 (cnt_pop + (push ? ONE_W : '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      ins_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (redirect_valid) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) begin
          pc_q[wr_q]  <= push_pc;
          ins_q[wr_q] <= push_ins;
          wr_q        <= wr_q + AW'(1);
        end
        if (pop)
          rd_q <= rd_q + AW'(1);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mis_q <= '0;
    else if (push && !redirect_valid)
      mis_q[wr_q] <= push_mis;
  end
`endif

endmodule
